// File: rtl/sram_port_arbiter_if.sv
// Bundles the two requester ports and the SRAM strobe/response bus of sram_port_arbiter.
// The arbiter uses the slave view; whoever drives requests and models the memory uses master.
interface sram_port_arbiter_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
);
    logic                  p0_req;
    logic                  p1_req;
    logic                  p0_wr;
    logic                  p1_wr;
    logic [ADDR_WIDTH-1:0] p0_addr;
    logic [ADDR_WIDTH-1:0] p1_addr;
    logic [DATA_WIDTH-1:0] p0_wdata;
    logic [DATA_WIDTH-1:0] p1_wdata;
    logic                  p0_gnt;
    logic                  p1_gnt;
    logic                  p0_ack;
    logic                  p1_ack;
    logic                  p0_err;
    logic                  p1_err;
    logic [DATA_WIDTH-1:0] p0_rdata;
    logic [DATA_WIDTH-1:0] p1_rdata;
    logic                  mem_wr;
    logic                  mem_rd;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  mem_response;

    modport slave (
        input  p0_req, p1_req, p0_wr, p1_wr, p0_addr, p1_addr, p0_wdata, p1_wdata,
        input  mem_rdata, mem_response,
        output p0_gnt, p1_gnt, p0_ack, p1_ack, p0_err, p1_err, p0_rdata, p1_rdata,
        output mem_wr, mem_rd, mem_addr, mem_wdata
    );

    modport master (
        output p0_req, p1_req, p0_wr, p1_wr, p0_addr, p1_addr, p0_wdata, p1_wdata,
        output mem_rdata, mem_response,
        input  p0_gnt, p1_gnt, p0_ack, p1_ack, p0_err, p1_err, p0_rdata, p1_rdata,
        input  mem_wr, mem_rd, mem_addr, mem_wdata
    );
endinterface

// File: rtl/sram_port_arbiter.sv
// Two-port round-robin arbiter that sequences single read/write transactions onto one SRAM port,
// with a bounded wait for the memory response and registered gnt/ack/err/rdata per port.
module sram_port_arbiter #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                clk,
    input  logic                reset,
    sram_port_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    // Counter value seen in the last BUSY cycle before an unanswered access is abandoned.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_e                state_q;
    logic                  ptr_q;
    logic                  sel_q;
    logic                  cmd_wr_q;
    logic [7:0]            cnt_q;
    logic [1:0]            gnt_q;
    logic [1:0]            ack_q;
    logic [1:0]            err_q;
    logic                  mem_wr_q;
    logic                  mem_rd_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [DATA_WIDTH-1:0] mem_wdata_q;
    logic [DATA_WIDTH-1:0] rdata0_q;
    logic [DATA_WIDTH-1:0] rdata1_q;

    logic                  sel_d;
    logic                  wr_d;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic [DATA_WIDTH-1:0] wdata_d;

    // A lone requester always wins; the pointer only breaks ties.
    always_comb begin
        sel_d   = (bus.p0_req && bus.p1_req) ? ptr_q : bus.p1_req;
        wr_d    = sel_d ? bus.p1_wr    : bus.p0_wr;
        addr_d  = sel_d ? bus.p1_addr  : bus.p0_addr;
        wdata_d = sel_d ? bus.p1_wdata : bus.p0_wdata;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            ptr_q       <= 1'b0;
            sel_q       <= 1'b0;
            cmd_wr_q    <= 1'b0;
            cnt_q       <= '0;
            gnt_q       <= '0;
            ack_q       <= '0;
            err_q       <= '0;
            mem_wr_q    <= 1'b0;
            mem_rd_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
        end else begin
            gnt_q <= '0;
            ack_q <= '0;
            err_q <= '0;
            case (state_q)
                IDLE: begin
                    if (bus.p0_req || bus.p1_req) begin
                        state_q       <= BUSY;
                        sel_q         <= sel_d;
                        cmd_wr_q      <= wr_d;
                        mem_addr_q    <= addr_d;
                        mem_wdata_q   <= wdata_d;
                        mem_wr_q      <= wr_d;
                        mem_rd_q      <= ~wr_d;
                        gnt_q[sel_d]  <= 1'b1;
                        cnt_q         <= '0;
                    end
                end
                BUSY: begin
                    // A response in the final allowed cycle still counts as success.
                    if (bus.mem_response) begin
                        state_q      <= DONE;
                        mem_wr_q     <= 1'b0;
                        mem_rd_q     <= 1'b0;
                        ack_q[sel_q] <= 1'b1;
                        if (!cmd_wr_q) begin
                            if (sel_q) rdata1_q <= bus.mem_rdata;
                            else       rdata0_q <= bus.mem_rdata;
                        end
                    end else if (cnt_q == CNT_LAST) begin
                        state_q      <= DONE;
                        mem_wr_q     <= 1'b0;
                        mem_rd_q     <= 1'b0;
                        ack_q[sel_q] <= 1'b1;
                        err_q[sel_q] <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                DONE: begin
                    ptr_q   <= ~sel_q;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.p0_gnt    = gnt_q[0];
    assign bus.p1_gnt    = gnt_q[1];
    assign bus.p0_ack    = ack_q[0];
    assign bus.p1_ack    = ack_q[1];
    assign bus.p0_err    = err_q[0];
    assign bus.p1_err    = err_q[1];
    assign bus.p0_rdata  = rdata0_q;
    assign bus.p1_rdata  = rdata1_q;
    assign bus.mem_wr    = mem_wr_q;
    assign bus.mem_rd    = mem_rd_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: plays both requesters and the SRAM, predicts every output cycle
// from a transaction-level schedule, and pins that schedule with hand-computed literals.
module tb_sram_port_arbiter;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam int TO = 4;

    typedef struct packed {
        logic [1:0]    gnt;
        logic [1:0]    ack;
        logic [1:0]    err;
        logic          wr;
        logic          rd;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rd0;
        logic [DW-1:0] rd1;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    sram_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    sram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] memArr [32];
    int respAt = 1;
    bit idleNoise = 1'b0;
    int busyCnt = 0;

    exp_t expQ[$];
    int remaining = 0;
    bit mPtr = 1'b0;
    logic [DW-1:0] mRd [2];
    bit modelValid = 1'b0;
    int mPort;
    bit mWr;
    bit mOk;
    int mDur;
    logic [AW-1:0] mAddr;
    logic [DW-1:0] mWdata;
    exp_t mE;
    exp_t cE;

    int gntOrder[$];
    int busyRun = 0;
    int lastBusyLen = 0;
    int ackCnt [2];
    logic [AW-1:0] lastRdAddr;
    int lat0, lat1, latX;
    int ackBefore;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Memory: answers in the respAt-th strobe cycle (never when respAt is 0).
    always @(negedge clk) begin
        if (bus.mem_wr || bus.mem_rd) begin
            busyCnt++;
            if (respAt != 0 && busyCnt == respAt) begin
                bus.mem_response = 1'b1;
                bus.mem_rdata    = memArr[bus.mem_addr];
                if (bus.mem_wr) memArr[bus.mem_addr] = bus.mem_wdata;
            end else begin
                bus.mem_response = 1'b0;
                bus.mem_rdata    = 32'hDEAD_0000 | 32'(busyCnt);
            end
        end else begin
            busyCnt          = 0;
            bus.mem_response = idleNoise;
            bus.mem_rdata    = 32'hBAD0_BAD0;
        end
    end

    // Model: when idle and a request is seen, lay out the whole transaction's cycles at once.
    always @(posedge clk) begin
        if (!reset) begin
            expQ.delete();
            remaining  = 0;
            mPtr       = 1'b0;
            mRd[0]     = '0;
            mRd[1]     = '0;
            modelValid = 1'b1;
        end else if (remaining > 0) begin
            remaining--;
        end else if (bus.p0_req || bus.p1_req) begin
            mPort  = (bus.p0_req && bus.p1_req) ? int'(mPtr) : (bus.p1_req ? 1 : 0);
            mWr    = (mPort == 1) ? bus.p1_wr : bus.p0_wr;
            mAddr  = (mPort == 1) ? bus.p1_addr : bus.p0_addr;
            mWdata = (mPort == 1) ? bus.p1_wdata : bus.p0_wdata;
            mOk    = (respAt != 0) && (respAt <= TO);
            mDur   = mOk ? respAt : TO;
            for (int k = 1; k <= mDur; k++) begin
                mE            = '0;
                mE.gnt[mPort] = (k == 1);
                mE.wr         = mWr;
                mE.rd         = !mWr;
                mE.addr       = mAddr;
                mE.wdata      = mWdata;
                mE.rd0        = mRd[0];
                mE.rd1        = mRd[1];
                expQ.push_back(mE);
            end
            if (mOk && !mWr) mRd[mPort] = memArr[mAddr];
            mE            = '0;
            mE.ack[mPort] = 1'b1;
            mE.err[mPort] = !mOk;
            mE.rd0        = mRd[0];
            mE.rd1        = mRd[1];
            expQ.push_back(mE);
            mPtr      = (mPort == 0);
            remaining = mDur + 1;
        end
    end

    // Compare every cycle against the schedule; an empty schedule means an idle cycle.
    always @(negedge clk) begin
        if (modelValid) begin
            if (expQ.size() > 0) begin
                cE = expQ.pop_front();
            end else begin
                cE     = '0;
                cE.rd0 = mRd[0];
                cE.rd1 = mRd[1];
            end
            checkOutput("p0_gnt", 32'(bus.p0_gnt), 32'(cE.gnt[0]));
            checkOutput("p1_gnt", 32'(bus.p1_gnt), 32'(cE.gnt[1]));
            checkOutput("p0_ack", 32'(bus.p0_ack), 32'(cE.ack[0]));
            checkOutput("p1_ack", 32'(bus.p1_ack), 32'(cE.ack[1]));
            checkOutput("p0_err", 32'(bus.p0_err), 32'(cE.err[0]));
            checkOutput("p1_err", 32'(bus.p1_err), 32'(cE.err[1]));
            checkOutput("mem_wr", 32'(bus.mem_wr), 32'(cE.wr));
            checkOutput("mem_rd", 32'(bus.mem_rd), 32'(cE.rd));
            checkOutput("p0_rdata", bus.p0_rdata, cE.rd0);
            checkOutput("p1_rdata", bus.p1_rdata, cE.rd1);
            checkOutput("strobe_excl", 32'(bus.mem_wr & bus.mem_rd), 32'd0);
            if (cE.wr || cE.rd) begin
                checkOutput("mem_addr", 32'(bus.mem_addr), 32'(cE.addr));
                checkOutput("mem_wdata", bus.mem_wdata, cE.wdata);
            end
            if (bus.p0_gnt) begin gntOrder.push_back(0); busyRun = 0; end
            if (bus.p1_gnt) begin gntOrder.push_back(1); busyRun = 0; end
            if (bus.mem_wr || bus.mem_rd) busyRun++;
            if (bus.mem_rd) lastRdAddr = bus.mem_addr;
            if (bus.p0_ack) begin ackCnt[0]++; lastBusyLen = busyRun; end
            if (bus.p1_ack) begin ackCnt[1]++; lastBusyLen = busyRun; end
        end
    end

    task automatic driveReq(input int port, input bit v, input bit wr,
                            input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        if (port == 0) begin
            bus.p0_req = v; bus.p0_wr = wr; bus.p0_addr = addr; bus.p0_wdata = wd;
        end else begin
            bus.p1_req = v; bus.p1_wr = wr; bus.p1_addr = addr; bus.p1_wdata = wd;
        end
    endtask

    task automatic waitGnt(input int port, output int cyc);
        bit seen = 1'b0;
        cyc = 0;
        while (!seen && cyc < 40) begin
            @(negedge clk);
            cyc++;
            seen = (port == 0) ? bus.p0_gnt : bus.p1_gnt;
        end
        if (!seen) checkOutput("gnt_wait_expired", 32'd0, 32'd1);
    endtask

    task automatic waitAck(input int port);
        bit seen = 1'b0;
        int cyc = 0;
        while (!seen && cyc < 40) begin
            @(negedge clk);
            cyc++;
            seen = (port == 0) ? bus.p0_ack : bus.p1_ack;
        end
        if (!seen) checkOutput("ack_wait_expired", 32'd0, 32'd1);
    endtask

    // Holds req for n grants, then withdraws it in the cycle of the last grant.
    task automatic applyStimulus(input int port, input bit wr, input logic [AW-1:0] addr,
                                 input logic [DW-1:0] wd, input int n, output int firstLat);
        int cyc;
        driveReq(port, 1'b1, wr, addr, wd);
        waitGnt(port, firstLat);
        for (int i = 1; i < n; i++) waitGnt(port, cyc);
        driveReq(port, 1'b0, wr, addr, wd);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not end, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < 32; i++) memArr[i] = 32'h1000 + 32'(i * 17);
        ackCnt[0] = 0;
        ackCnt[1] = 0;
        driveReq(0, 1'b1, 1'b0, '0, '0);
        driveReq(1, 1'b0, 1'b0, '0, '0);

        // Reset held with a pending request
        repeat (2) @(negedge clk);
        checkOutput("rst_p0_gnt", 32'(bus.p0_gnt), 32'd0);
        checkOutput("rst_mem_wr", 32'(bus.mem_wr), 32'd0);
        checkOutput("rst_mem_rd", 32'(bus.mem_rd), 32'd0);
        checkOutput("rst_p0_rdata", bus.p0_rdata, 32'd0);
        driveReq(0, 1'b0, 1'b0, '0, '0);
        reset = 1'b1;
        @(negedge clk);

        // Port 0 write then read back
        respAt = 2;
        applyStimulus(0, 1'b1, 5'd3, 32'd50, 1, lat0);
        checkOutput("wr_gnt_latency", 32'(lat0), 32'd1);
        waitAck(0);
        checkOutput("wr_p0_err", 32'(bus.p0_err), 32'd0);
        @(negedge clk);
        respAt = 1;
        applyStimulus(0, 1'b0, 5'd3, 32'd0, 1, lat0);
        waitAck(0);
        @(negedge clk);
        checkOutput("rd_mem_addr", 32'(lastRdAddr), 32'd3);
        checkOutput("rd_p0_rdata", bus.p0_rdata, 32'd50);

        // One p1 transaction so the pointer favours port 0 again
        applyStimulus(1, 1'b0, 5'd9, 32'd0, 1, lat1);
        waitAck(1);
        @(negedge clk);
        checkOutput("p1_rdata_addr9", bus.p1_rdata, 32'h1099);

        // Contention, with response noise outside BUSY
        idleNoise = 1'b1;
        gntOrder.delete();
        fork
            applyStimulus(0, 1'b0, 5'd1, 32'd0, 2, lat0);
            applyStimulus(1, 1'b0, 5'd2, 32'd0, 2, lat1);
        join
        waitAck(1);
        @(negedge clk);
        idleNoise = 1'b0;
        checkOutput("cont_gnt_count", 32'(gntOrder.size()), 32'd4);
        for (int i = 0; i < gntOrder.size() && i < 4; i++)
            checkOutput("cont_gnt_order", 32'(gntOrder[i]), 32'(i % 2));
        checkOutput("cont_p1_rdata", bus.p1_rdata, 32'h1022);
        checkOutput("cont_p0_rdata", bus.p0_rdata, 32'h1011);

        // Timeout, then a normal read on the same port
        respAt = 0;
        applyStimulus(1, 1'b0, 5'd7, 32'd0, 1, lat1);
        waitAck(1);
        checkOutput("to_p1_err", 32'(bus.p1_err), 32'd1);
        @(negedge clk);
        checkOutput("to_busy_len", 32'(lastBusyLen), 32'd4);
        checkOutput("to_p1_rdata_kept", bus.p1_rdata, 32'h1022);
        respAt = 1;
        applyStimulus(1, 1'b0, 5'd7, 32'd0, 1, lat1);
        waitAck(1);
        checkOutput("after_to_p1_err", 32'(bus.p1_err), 32'd0);
        @(negedge clk);
        checkOutput("after_to_p1_rdata", bus.p1_rdata, 32'h1077);

        // Response in the last allowed BUSY cycle
        respAt = 4;
        applyStimulus(0, 1'b0, 5'd3, 32'd0, 1, lat0);
        waitAck(0);
        checkOutput("expiry_p0_err", 32'(bus.p0_err), 32'd0);
        @(negedge clk);
        checkOutput("expiry_busy_len", 32'(lastBusyLen), 32'd4);
        checkOutput("expiry_p0_rdata", bus.p0_rdata, 32'd50);

        // Reset in the second BUSY cycle of a p0 write
        respAt = 0;
        applyStimulus(0, 1'b1, 5'd5, 32'h55, 1, lat0);
        @(negedge clk);
        ackBefore = ackCnt[0];
        reset = 1'b0;
        @(negedge clk);
        checkOutput("midrst_mem_wr", 32'(bus.mem_wr), 32'd0);
        checkOutput("midrst_mem_rd", 32'(bus.mem_rd), 32'd0);
        checkOutput("midrst_p0_rdata", bus.p0_rdata, 32'd0);
        reset = 1'b1;
        repeat (6) @(negedge clk);
        checkOutput("midrst_no_ack", 32'(ackCnt[0]), 32'(ackBefore));
        respAt = 1;
        gntOrder.delete();
        fork
            applyStimulus(0, 1'b0, 5'd4, 32'd0, 1, lat0);
            applyStimulus(1, 1'b0, 5'd6, 32'd0, 1, lat1);
        join
        waitAck(1);
        @(negedge clk);
        checkOutput("midrst_gnt_count", 32'(gntOrder.size()), 32'd2);
        if (gntOrder.size() >= 2) begin
            checkOutput("midrst_first_gnt", 32'(gntOrder[0]), 32'd0);
            checkOutput("midrst_second_gnt", 32'(gntOrder[1]), 32'd1);
        end
        latX = lat0 + lat1;

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
